// File: rtl/reservation_station_pkg.sv
// Shared types for the ALU reservation station.
//   alu_ops    : ALU operation encoding (alu_add is 0, so an idle issue port reads as alu_add)
//   rob_tag_t  : reorder-buffer tag, TAG_BITS wide (ROB of 8 entries -> 3 bits)
//   rs_entry_t : one station slot (busy flag, op, operand values/tags/pending bits, dest tag)
package reservation_station_pkg;

    localparam int TAG_BITS = 3;

    typedef logic [TAG_BITS-1:0] rob_tag_t;

    typedef enum logic [2:0] {
        alu_add = 3'd0,
        alu_sll = 3'd1,
        alu_sra = 3'd2,
        alu_sub = 3'd3,
        alu_xor = 3'd4,
        alu_srl = 3'd5,
        alu_or  = 3'd6,
        alu_and = 3'd7
    } alu_ops;

    typedef struct packed {
        logic        busy;
        alu_ops      op;
        logic [31:0] vj;
        logic [31:0] vk;
        rob_tag_t    qj;
        rob_tag_t    qk;
        logic        qj_pend;
        logic        qk_pend;
        rob_tag_t    dest;
    } rs_entry_t;

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit priority encoder.
//   req   : request vector, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when none set)
//   found : at least one request bit is set
module rs_priority_enc #(
    parameter int n     = 4,
    parameter int idx_w = (n > 1) ? $clog2(n) : 1
) (
    input  logic [n-1:0]     req,
    output logic [idx_w-1:0] idx,
    output logic             found
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = idx_w'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order ALU reservation station. Holds dispatched ops until both
// operands are known, snoops the CDB for tagged results, and issues the
// lowest-index ready op to the ALU with a valid/ready handshake.
//   clk, rst (sync, active-low), flush (clears all slots)
//   dispatch : load_i, op_i, vj_i/vk_i, qj_i/qk_i, qj_valid_i/qk_valid_i, rob_tag_i, full_o
//   CDB      : cdb_valid_i, cdb_tag_i, cdb_val_i
//   issue    : alu_valid_o, alu_ready_i, alu_op_o, alu_a_o, alu_b_o, alu_tag_o
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int entries  = 4,
    parameter int tag_bits = TAG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                load_i,
    input  alu_ops              op_i,
    input  logic [31:0]         vj_i,
    input  logic [31:0]         vk_i,
    input  logic [tag_bits-1:0] qj_i,
    input  logic [tag_bits-1:0] qk_i,
    input  logic                qj_valid_i,
    input  logic                qk_valid_i,
    input  logic [tag_bits-1:0] rob_tag_i,
    output logic                full_o,
    input  logic                cdb_valid_i,
    input  logic [tag_bits-1:0] cdb_tag_i,
    input  logic [31:0]         cdb_val_i,
    output logic                alu_valid_o,
    input  logic                alu_ready_i,
    output alu_ops              alu_op_o,
    output logic [31:0]         alu_a_o,
    output logic [31:0]         alu_b_o,
    output logic [tag_bits-1:0] alu_tag_o
);

    localparam int IDX_W = (entries > 1) ? $clog2(entries) : 1;

    rs_entry_t          slots [entries];
    logic [entries-1:0] busy_vec;
    logic [entries-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   rdy_idx;
    logic               free_found;
    logic               rdy_found;
    logic               dispatch;
    logic               issue;
    logic               bypass_j;
    logic               bypass_k;

    // Readiness looks only at registered pending bits, so a CDB capture
    // becomes issuable one cycle after the broadcast.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < entries; i++) begin
            busy_vec[i]  = slots[i].busy;
            ready_vec[i] = slots[i].busy && !slots[i].qj_pend && !slots[i].qk_pend;
        end
    end

    rs_priority_enc #(.n(entries), .idx_w(IDX_W)) u_free_sel (
        .req   (~busy_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_enc #(.n(entries), .idx_w(IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .idx   (rdy_idx),
        .found (rdy_found)
    );

    // The free set is pre-edge state, so a slot issued this cycle is not
    // reusable until the next one and full_o stays high meanwhile.
    assign full_o      = &busy_vec;
    assign dispatch    = load_i && free_found && !flush;
    assign alu_valid_o = rdy_found && !flush;
    assign issue       = alu_valid_o && alu_ready_i;

    assign bypass_j = qj_valid_i && cdb_valid_i && (qj_i == cdb_tag_i);
    assign bypass_k = qk_valid_i && cdb_valid_i && (qk_i == cdb_tag_i);

    always_comb begin
        alu_op_o  = alu_add;
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_tag_o = '0;
        if (alu_valid_o) begin
            alu_op_o  = slots[rdy_idx].op;
            alu_a_o   = slots[rdy_idx].vj;
            alu_b_o   = slots[rdy_idx].vk;
            alu_tag_o = slots[rdy_idx].dest;
        end
    end

    // Only busy is reset; payload fields are meaningless while busy is low.
    // Issue, snoop and dispatch never target the same field of one slot:
    // dispatch only writes a slot that was free before this edge.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < entries; i++) begin
                slots[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < entries; i++) begin
                if (issue && rdy_idx == IDX_W'(i)) begin
                    slots[i].busy <= 1'b0;
                end
                if (slots[i].busy && cdb_valid_i) begin
                    if (slots[i].qj_pend && slots[i].qj == cdb_tag_i) begin
                        slots[i].vj      <= cdb_val_i;
                        slots[i].qj_pend <= 1'b0;
                    end
                    if (slots[i].qk_pend && slots[i].qk == cdb_tag_i) begin
                        slots[i].vk      <= cdb_val_i;
                        slots[i].qk_pend <= 1'b0;
                    end
                end
                if (dispatch && free_idx == IDX_W'(i)) begin
                    slots[i].busy    <= 1'b1;
                    slots[i].op      <= op_i;
                    slots[i].vj      <= bypass_j ? cdb_val_i : vj_i;
                    slots[i].vk      <= bypass_k ? cdb_val_i : vk_i;
                    slots[i].qj      <= rob_tag_t'(qj_i);
                    slots[i].qk      <= rob_tag_t'(qk_i);
                    slots[i].qj_pend <= qj_valid_i && !bypass_j;
                    slots[i].qk_pend <= qk_valid_i && !bypass_k;
                    slots[i].dest    <= rob_tag_t'(rob_tag_i);
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        load_i = 1'b0;
    alu_ops      op_i = alu_add;
    logic [31:0] vj_i = '0;
    logic [31:0] vk_i = '0;
    logic [2:0]  qj_i = '0;
    logic [2:0]  qk_i = '0;
    logic        qj_valid_i = 1'b0;
    logic        qk_valid_i = 1'b0;
    logic [2:0]  rob_tag_i = '0;
    logic        full_o;
    logic        cdb_valid_i = 1'b0;
    logic [2:0]  cdb_tag_i = '0;
    logic [31:0] cdb_val_i = '0;
    logic        alu_valid_o;
    logic        alu_ready_i = 1'b0;
    alu_ops      alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [2:0]  alu_tag_o;

    reservation_station #(.entries(N), .tag_bits(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .load_i      (load_i),
        .op_i        (op_i),
        .vj_i        (vj_i),
        .vk_i        (vk_i),
        .qj_i        (qj_i),
        .qk_i        (qk_i),
        .qj_valid_i  (qj_valid_i),
        .qk_valid_i  (qk_valid_i),
        .rob_tag_i   (rob_tag_i),
        .full_o      (full_o),
        .cdb_valid_i (cdb_valid_i),
        .cdb_tag_i   (cdb_tag_i),
        .cdb_val_i   (cdb_val_i),
        .alu_valid_o (alu_valid_o),
        .alu_ready_i (alu_ready_i),
        .alu_op_o    (alu_op_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_tag_o   (alu_tag_o)
    );

    always #5 clk = ~clk;

    // Expected combinational outputs for one cycle.
    typedef struct {
        bit          chk;
        bit          full;
        bit          valid;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  tag;
    } exp_t;

    exp_t sb[$];

    // Reference model: a set of held ops with operand values and pending tags.
    bit          m_busy [N];
    logic [2:0]  m_op   [N];
    logic [31:0] m_vj   [N];
    logic [31:0] m_vk   [N];
    logic [2:0]  m_qj   [N];
    logic [2:0]  m_qk   [N];
    bit          m_pj   [N];
    bit          m_pk   [N];
    logic [2:0]  m_dest [N];
    bit          m_known = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge with inputs already driven: predict this
    // cycle's outputs, then advance the model across the posedge.
    task automatic step();
        exp_t e;
        int   sel;
        int   fr;
        #1;
        e.chk  = m_known;
        e.full = 1'b1;
        for (int i = 0; i < N; i++) if (!m_busy[i]) e.full = 1'b0;
        sel = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_busy[i] && !m_pj[i] && !m_pk[i]) sel = i;
        e.valid = (sel >= 0) && !flush;
        e.op = '0; e.a = '0; e.b = '0; e.tag = '0;
        if (e.valid) begin
            e.op = m_op[sel]; e.a = m_vj[sel]; e.b = m_vk[sel]; e.tag = m_dest[sel];
        end
        sb.push_back(e);
        fr = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
        @(posedge clk);
        if (!rst || flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            if (!rst) m_known = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && cdb_valid_i) begin
                    if (m_pj[i] && m_qj[i] == cdb_tag_i) begin m_vj[i] = cdb_val_i; m_pj[i] = 1'b0; end
                    if (m_pk[i] && m_qk[i] == cdb_tag_i) begin m_vk[i] = cdb_val_i; m_pk[i] = 1'b0; end
                end
            end
            if (e.valid && alu_ready_i) m_busy[sel] = 1'b0;
            if (load_i && fr >= 0) begin
                m_busy[fr] = 1'b1;
                m_op[fr]   = 3'(op_i);
                m_qj[fr]   = qj_i;
                m_qk[fr]   = qk_i;
                m_dest[fr] = rob_tag_i;
                m_pj[fr]   = qj_valid_i && !(cdb_valid_i && qj_i == cdb_tag_i);
                m_pk[fr]   = qk_valid_i && !(cdb_valid_i && qk_i == cdb_tag_i);
                m_vj[fr]   = (qj_valid_i && !m_pj[fr]) ? cdb_val_i : vj_i;
                m_vk[fr]   = (qk_valid_i && !m_pk[fr]) ? cdb_val_i : vk_i;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b1; flush = 1'b0; load_i = 1'b0; cdb_valid_i = 1'b0;
        qj_valid_i = 1'b0; qk_valid_i = 1'b0;
    endtask

    task automatic disp(input alu_ops op, input logic [31:0] a, input logic [31:0] b,
                        input bit pj, input logic [2:0] tj, input bit pk, input logic [2:0] tk,
                        input logic [2:0] dest);
        load_i = 1'b1; op_i = op; vj_i = a; vk_i = b;
        qj_valid_i = pj; qj_i = tj; qk_valid_i = pk; qk_i = tk; rob_tag_i = dest;
    endtask

    // Monitor: pops the expectation for each cycle and compares outputs.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("full_o", 32'(full_o), 32'(e.full));
                    check("alu_valid_o", 32'(alu_valid_o), 32'(e.valid));
                    check("alu_op_o", 32'(alu_op_o), 32'(e.op));
                    check("alu_a_o", alu_a_o, e.a);
                    check("alu_b_o", alu_b_o, e.b);
                    check("alu_tag_o", 32'(alu_tag_o), 32'(e.tag));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // Reset held two cycles with load asserted.
        rst = 1'b0; load_i = 1'b1; vj_i = 32'h1; vk_i = 32'h2;
        step(); step();
        // Simple dispatch, immediate issue.
        idle(); alu_ready_i = 1'b1;
        disp(alu_add, 32'd5, 32'd7, 1'b0, 3'd0, 1'b0, 3'd0, 3'd2); step();
        idle(); step(); step();
        // Operand j waits on tag 4, broadcast two cycles later.
        disp(alu_sub, 32'd0, 32'd3, 1'b1, 3'd4, 1'b0, 3'd0, 3'd5); step();
        idle(); step();
        cdb_valid_i = 1'b1; cdb_tag_i = 3'd4; cdb_val_i = 32'h10; step();
        idle(); step(); step();
        // Same-cycle bypass on operand k.
        disp(alu_xor, 32'd9, 32'd0, 1'b0, 3'd0, 1'b1, 3'd6, 3'd1);
        cdb_valid_i = 1'b1; cdb_tag_i = 3'd6; cdb_val_i = 32'hABCD; step();
        idle(); step(); step();
        // Fill all slots pending on tag 1; fifth load must be dropped.
        alu_ready_i = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            disp(alu_ops'(i), 32'(i), 32'(100 + i), 1'b1, 3'd1, 1'b0, 3'd0, 3'(i)); step();
        end
        idle(); cdb_valid_i = 1'b1; cdb_tag_i = 3'd1; cdb_val_i = 32'h55; step();
        idle(); step();
        alu_ready_i = 1'b1;
        for (int i = 0; i < N + 1; i++) step();
        // Full station with slot 2 ready, then flush.
        alu_ready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            disp(alu_or, 32'(i), 32'd1, (i != 2), 3'd3, 1'b0, 3'd0, 3'(i + 4)); step();
        end
        idle(); alu_ready_i = 1'b1; flush = 1'b1; step();
        idle(); step(); step();
        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 99) >= 2);
            flush       = ($urandom_range(0, 99) < 3);
            load_i      = ($urandom_range(0, 99) < 60);
            op_i        = alu_ops'($urandom_range(0, 7));
            vj_i        = $urandom;
            vk_i        = $urandom;
            qj_i        = 3'($urandom_range(0, 7));
            qk_i        = 3'($urandom_range(0, 7));
            qj_valid_i  = ($urandom_range(0, 1) == 1);
            qk_valid_i  = ($urandom_range(0, 1) == 1);
            rob_tag_i   = 3'($urandom_range(0, 7));
            cdb_valid_i = ($urandom_range(0, 99) < 50);
            cdb_tag_i   = 3'($urandom_range(0, 7));
            cdb_val_i   = $urandom;
            alu_ready_i = ($urandom_range(0, 99) < 60);
            step();
        end
        idle(); step(); step();
        done = 1'b1;
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
